// File: rtl/sdram_port_arbiter_if.sv
// Requester, SDRAM-controller command and status signals of the SDRAM port arbiter.
// The master modport is the arbiter; the slave modport is the surrounding SoC.
interface sdram_port_arbiter_if #(
    parameter int ADDR_W = 22
);
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_ack;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_ack;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic              dma_ack;

    logic [2:0]        grant;

    logic              mem_valid;
    logic              mem_ready;
    logic              mem_refresh;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_done;

    logic              ref_overrun;

    modport master (
        input  vga_req, vga_addr, cpu_req, cpu_we, cpu_addr,
        input  dma_req, dma_we, dma_addr, mem_ready, mem_done,
        output vga_ack, cpu_ack, dma_ack, grant,
        output mem_valid, mem_refresh, mem_we, mem_addr, ref_overrun
    );

    modport slave (
        output vga_req, vga_addr, cpu_req, cpu_we, cpu_addr,
        output dma_req, dma_we, dma_addr, mem_ready, mem_done,
        input  vga_ack, cpu_ack, dma_ack, grant,
        input  mem_valid, mem_refresh, mem_we, mem_addr, ref_overrun
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller command port between VGA, CPU and DMA requesters and
// interleaves periodic auto-refresh; data buses are steered outside by the one-hot grant.
module sdram_port_arbiter #(
    parameter int ADDR_W      = 22,
    parameter int REFRESH_CYC = 390,
    parameter int PEND_MAX    = 7
) (
    input logic                 clk,
    input logic                 rst,
    sdram_port_arbiter_if.master bus
);
    localparam int CNT_W  = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;
    localparam int PEND_W = $clog2(PEND_MAX + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(REFRESH_CYC - 1);
    localparam logic [PEND_W-1:0] PEND_FULL = PEND_W'(PEND_MAX);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    typedef enum logic [2:0] {
        PICK_NONE,
        PICK_REF,
        PICK_VGA,
        PICK_CPU,
        PICK_DMA
    } pick_t;

    state_t            state;
    pick_t             pick;
    logic [CNT_W-1:0]  ref_cnt;
    logic [PEND_W-1:0] pend;
    logic              ref_overrun_q;
    logic              rr_last;        // 1: CPU served last, 0: DMA served last
    logic [2:0]        grant_q;
    logic              mem_valid_q;
    logic              mem_refresh_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;

    logic wrap;
    logic ref_taken;
    logic done_hit;

    assign wrap      = (ref_cnt == CNT_LAST);
    assign ref_taken = (state == ISSUE) && mem_valid_q && bus.mem_ready && mem_refresh_q;

    // NOTE: rst is synchronous, so it must appear inside the clocked block and nowhere in the sensitivity list.
    always_ff @(posedge clk) begin
        if (rst) begin
            ref_cnt       <= '0;
            pend          <= '0;
            ref_overrun_q <= 1'b0;
        end else begin
            // NOTE: state is updated with <= so every flop samples the pre-edge values of the others.
            ref_cnt <= wrap ? '0 : ref_cnt + CNT_W'(1);
            if (wrap && (pend == PEND_FULL))
                ref_overrun_q <= 1'b1;
            if (wrap && !ref_taken && (pend != PEND_FULL))
                pend <= pend + PEND_W'(1);
            else if (ref_taken && !wrap)
                pend <= pend - PEND_W'(1);
        end
    end

    // Refresh first, then VGA, then CPU/DMA alternating when both are waiting.
    always_comb begin
        // NOTE: pick gets a value before any branch so no path leaves it unassigned (no latch).
        pick = PICK_NONE;
        if (pend != '0)
            pick = PICK_REF;
        else if (bus.vga_req)
            pick = PICK_VGA;
        else if (bus.cpu_req && (!bus.dma_req || !rr_last))
            pick = PICK_CPU;
        else if (bus.dma_req)
            pick = PICK_DMA;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            rr_last       <= 1'b0;
            grant_q       <= 3'b000;
            mem_valid_q   <= 1'b0;
            mem_refresh_q <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    case (pick)
                        PICK_REF: begin
                            grant_q       <= 3'b000;
                            mem_refresh_q <= 1'b1;
                            mem_we_q      <= 1'b0;
                            mem_addr_q    <= '0;
                        end
                        PICK_VGA: begin
                            grant_q       <= 3'b001;
                            mem_refresh_q <= 1'b0;
                            mem_we_q      <= 1'b0;
                            mem_addr_q    <= bus.vga_addr;
                        end
                        PICK_CPU: begin
                            grant_q       <= 3'b010;
                            mem_refresh_q <= 1'b0;
                            mem_we_q      <= bus.cpu_we;
                            mem_addr_q    <= bus.cpu_addr;
                        end
                        PICK_DMA: begin
                            grant_q       <= 3'b100;
                            mem_refresh_q <= 1'b0;
                            mem_we_q      <= bus.dma_we;
                            mem_addr_q    <= bus.dma_addr;
                        end
                        default: begin
                            grant_q       <= 3'b000;
                            mem_refresh_q <= 1'b0;
                        end
                    endcase
                    if (pick != PICK_NONE) begin
                        state       <= ISSUE;
                        mem_valid_q <= 1'b1;
                    end
                end

                ISSUE: begin
                    if (bus.mem_ready) begin
                        state       <= WAIT;
                        mem_valid_q <= 1'b0;
                    end
                end

                WAIT: begin
                    if (bus.mem_done) begin
                        state         <= IDLE;
                        grant_q       <= 3'b000;
                        mem_refresh_q <= 1'b0;
                        if (grant_q[1])
                            rr_last <= 1'b1;
                        else if (grant_q[2])
                            rr_last <= 1'b0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    // Acks follow mem_done combinationally; a reset cycle aborts the access without an ack.
    assign done_hit = (state == WAIT) && bus.mem_done && !rst;

    assign bus.vga_ack     = done_hit && grant_q[0];
    assign bus.cpu_ack     = done_hit && grant_q[1];
    assign bus.dma_ack     = done_hit && grant_q[2];
    assign bus.grant       = grant_q;
    assign bus.mem_valid   = mem_valid_q;
    assign bus.mem_refresh = mem_refresh_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.ref_overrun = ref_overrun_q;
endmodule
